// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage with a small byte-addressed instruction memory
//   and an in-order fetch queue feeding decode.
//
//   The memory is filled byte by byte through the load port, including while
//   reset is held, and it is never cleared. Each fetch assembles one
//   little-endian word at fetch_pc and pushes {pc, word, fault} into the
//   queue.
//
//   A misaligned PC, or a word that would run past the end of memory, is
//   still enqueued, but as a fault entry carrying a NOP (32'h0000_0013).
//   After that entry the unit halts until the next redirect.
//
//   Ports
//     clk, rst_n            single clock, synchronous active-low reset
//     redirect, redirect_pc flush the queue and restart fetch at redirect_pc
//     load_en/addr/data     program-load byte write port
//     ins_valid, ins_ready  handshake for the queue head towards decode
//     instruction, ins_pc,
//     ins_fault             queue head contents (all zero when queue empty)
//     fetch_pc              current fetch PC register
module fetch_unit #(
    parameter int          MEM_BYTES  = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [7:0]  load_data,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] instruction,
    output logic [31:0] ins_pc,
    output logic        ins_fault,
    output logic [31:0] fetch_pc
);

    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t state;
    state_t next_state;

    logic [7:0] mem [MEM_BYTES];

    logic [31:0] q_pc    [FIFO_DEPTH];
    logic [31:0] q_word  [FIFO_DEPTH];
    logic        q_fault [FIFO_DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [32:0]   end_addr;
    logic [AW-1:0] rd_idx;
    logic          fetch_fault;
    logic [31:0]   fetch_word;
    logic          deq;
    logic          enq;

    // Program-load port; works regardless of reset so a program can be loaded
    // while the core is held in reset.
    always_ff @(posedge clk) begin
        if (load_en && (load_addr < 32'(MEM_BYTES))) begin
            mem[load_addr[AW-1:0]] <= load_data;
        end
    end

    // The end address is computed one bit wider so the range test cannot
    // wrap. The memory is only indexed when the whole word is in range.
    always_comb begin
        end_addr    = {1'b0, fetch_pc} + 33'd3;
        fetch_fault = (fetch_pc[1:0] != 2'b00) || (end_addr >= 33'(MEM_BYTES));
        rd_idx      = fetch_pc[AW-1:0];
        fetch_word  = NOP_WORD;
        if (!fetch_fault) begin
            fetch_word = {mem[rd_idx + AW'(3)], mem[rd_idx + AW'(2)],
                          mem[rd_idx + AW'(1)], mem[rd_idx]};
        end
    end

    // A full queue may still accept a new fetch when the head leaves on the
    // same edge. Redirect blocks both sides: the queue is being flushed.
    always_comb begin
        ins_valid = (count != '0) && !redirect;
        deq       = ins_valid && ins_ready;
        enq       = (state == RUN) && !redirect &&
                    ((count < CW'(FIFO_DEPTH)) || deq);
    end

    // Next-state logic: redirect always restarts fetch, and enqueuing a fault
    // entry parks the unit in HALT.
    always_comb begin
        next_state = state;
        if (redirect) begin
            next_state = RUN;
        end else if (enq && fetch_fault) begin
            next_state = HALT;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Queue pointers, occupancy and the fetch PC. Reset takes priority over
    // redirect, and redirect takes priority over the normal enqueue/dequeue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (enq) begin
                tail     <= tail + PW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage. It has no reset because count decides which entries
    // are meaningful.
    always_ff @(posedge clk) begin
        if (rst_n && !redirect && enq) begin
            q_pc[tail]    <= fetch_pc;
            q_word[tail]  <= fetch_word;
            q_fault[tail] <= fetch_fault;
        end
    end

    // The head is presented only while the queue holds something. Otherwise
    // the outputs read as zero.
    always_comb begin
        instruction = '0;
        ins_pc      = '0;
        ins_fault   = 1'b0;
        if (count != '0) begin
            instruction = q_word[head];
            ins_pc      = q_pc[head];
            ins_fault   = q_fault[head];
        end
    end

endmodule
